input_debouncer: RTL
====================

Name: input_debouncer

Overview:
- Board-input conditioning stage directly upstream of the Nios system's button and switch PIOs.
- Synchronises the raw DE10 KEY[3:0] (active-low) and SW[9:0] inputs into clk_clk.
- Debounces each bit with a per-bit stability counter and presents clean active-high levels to button_external_connection_export and switch_external_connection_export.
- Also produces one-cycle press/release pulses for fabric logic such as the paddle controller.

Parameters:
- N_BTN, 4: number of push-buttons.
- N_SW, 10: number of slide switches.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a level change is accepted (10 ms at 50 MHz); legal range 2 to 2^24.
- CNT_W, $clog2(DEBOUNCE_CYCLES): stability counter width.

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset_n  in  1  asynchronous active-low reset.
- key_n_in  in  N_BTN  raw push-buttons, active-low, asynchronous.
- sw_in  in  N_SW  raw slide switches, active-high, asynchronous.
- btn_level_out  out  N_BTN  debounced button level, 1 = pressed; feeds button PIO.
- sw_level_out  out  N_SW  debounced switch level; feeds switch PIO.
- btn_press_out  out  N_BTN  one-cycle pulse on debounced 0->1.
- btn_release_out  out  N_BTN  one-cycle pulse on debounced 1->0.
- btn_latch_out  out  N_BTN  sticky press flags (see Optional Feature).
- btn_latch_clr_in  in  N_BTN  per-bit latch clear (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk_clk. reset_reset_n is asynchronous, active-low; assertion clears all state immediately, and deassertion is synchronous to clk_clk.
- Synchroniser: 2-flop per bit. Button input is inverted before the first flop, so internal polarity is 1 = pressed. Synchroniser flops reset to 0.
- Reset values: every output is 0 and every counter is 0.
- Per-bit debounce, with sync = synchroniser output and state = debounced register:
  - sync == state: counter clears to 0.
  - sync != state and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != state and counter == DEBOUNCE_CYCLES-1: state <= sync, counter <= 0.
- Glitch rejection: any return of sync to state before the terminal count restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles never propagate.
- Latency: a clean raw edge reaches the level output in exactly 2 + DEBOUNCE_CYCLES clock cycles.
- Pulses (buttons only; switches have no pulses):
  - btn_press_out[i] is registered and high for exactly one cycle, the first cycle btn_level_out[i] reads 1.
  - btn_release_out[i] is the same for the first cycle btn_level_out[i] reads 0 after having been 1.
  - Press and release pulses for one bit are never simultaneous.
- Independence: all bits are independent, and simultaneous transitions on several bits each complete on their own schedule.
- Counter width: the counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- Reset mid-count: discards the partial count and outputs return to 0. A button held through reset produces a press pulse 2 + DEBOUNCE_CYCLES cycles after deassertion.

Optional Feature:
- Macro: INPUT_DEBOUNCER_BTN_LATCH_EN.
- Defined:
  - btn_latch_out[i] sets on btn_press_out[i] and clears on btn_latch_clr_in[i].
  - Set has priority when both occur in the same cycle.
  - Resets to 0.
  - Lets the Nios poll presses without missing short taps.
- Undefined: btn_latch_out is constant 0, btn_latch_clr_in is ignored, and no latch flops are synthesised.

Decomposition:
- Package pong_io_pkg holds:
  - N_BTN_DEF = 4, N_SW_DEF = 10.
  - CLK_HZ = 50_000_000, DEBOUNCE_MS = 10.
  - The derived DEBOUNCE_CYCLES constant.
- Sub-module debounce_bit (synchroniser + counter + state register, with parameters DEBOUNCE_CYCLES and CNT_W).
- Top instantiates debounce_bit N_BTN + N_SW times via generate and adds the edge/latch logic for buttons.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: hold reset_reset_n = 0 with key_n_in = 4'b0000 and sw_in = 10'h3FF -> all outputs 0. Release reset -> btn_level_out = 4'hF and sw_level_out = 10'h3FF at cycle 6, with btn_press_out = 4'hF for exactly that cycle.
- Clean press: key_n_in[0] 1->0 and held -> btn_level_out[0] rises 6 cycles later, btn_press_out[0] = 1 for one cycle. Release -> btn_release_out[0] pulses 6 cycles after the release.
- Glitch: key_n_in[2] low for 3 cycles, then high -> btn_level_out[2] stays 0 and no pulses occur. Bounce pattern 0,1,0,0,0,0 -> the level rises 4 stable cycles after the last bounce.
- Switches: sw_in toggles 10'h000 -> 10'h2A5 -> sw_level_out = 10'h2A5 after 6 cycles. A 2-cycle sw_in[9] pulse is ignored.
- Reset mid-count: assert reset_reset_n 2 cycles into a press count -> outputs 0 immediately. The count restarts from 0 after deassertion.
- With INPUT_DEBOUNCER_BTN_LATCH_EN:
  - A press sets btn_latch_out[1], which holds after release. btn_latch_clr_in[1] clears it the next cycle.
  - A clear coincident with a press pulse leaves it 1.
  - Without the macro, btn_latch_out == 0 throughout.

Source files
------------

// File: rtl/pong_io_pkg.sv
// rtl/pong_io_pkg.sv - shared constants for the board input conditioning stage
package pong_io_pkg;

  localparam int N_BTN_DEF   = 4;
  localparam int N_SW_DEF    = 10;
  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Cycles a raw level must stay put before it is accepted (10 ms at 50 MHz).
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser, stability counter and debounced state for one input
module debounce_bit
  import pong_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw_in,
  output logic level_out,
  output logic update_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_terminal;

  // Bring the asynchronous raw input into clk_clk through two flops.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differ   = (r_sync2 != r_state);
  assign w_terminal = (r_cnt == CNT_LAST);

  // High in the cycle before the debounced state flips; lets the parent register aligned edge pulses.
  assign update_out = w_differ & w_terminal;
  assign level_out  = r_state;

  // Count consecutive cycles of disagreement; any agreement restarts the count, so short glitches die here.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else if (!w_differ) begin
      r_cnt <= '0;
    end else if (w_terminal) begin
      r_cnt   <= '0;
      r_state <= r_sync2;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - debounced buttons/switches with press/release pulses; INPUT_DEBOUNCER_BTN_LATCH_EN adds sticky press flags
module input_debouncer
  import pong_io_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int N_SW            = N_SW_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] key_n_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_BTN-1:0] btn_level_out,
  output logic [N_SW-1:0]  sw_level_out,
  output logic [N_BTN-1:0] btn_press_out,
  output logic [N_BTN-1:0] btn_release_out,
  output logic [N_BTN-1:0] btn_latch_out,
  input  logic [N_BTN-1:0] btn_latch_clr_in
);

  logic [N_BTN-1:0] w_btn_raw;
  logic [N_BTN-1:0] w_btn_level;
  logic [N_BTN-1:0] w_btn_update;
  logic [N_SW-1:0]  w_sw_level;
  logic [N_SW-1:0]  w_sw_update_unused;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;

  // Keys are active-low on the board; flip them so everything downstream reads 1 = pressed.
  assign w_btn_raw = ~key_n_in;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_btn (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .raw_in        (w_btn_raw[gi]),
        .level_out     (w_btn_level[gi]),
        .update_out    (w_btn_update[gi])
      );
    end
    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_sw (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .raw_in        (sw_in[gi]),
        .level_out     (w_sw_level[gi]),
        .update_out    (w_sw_update_unused[gi])
      );
    end
  endgenerate

  // Register press/release from the pre-flip strobe so each pulse lands in the first cycle of the new level.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= w_btn_update & ~w_btn_level;
      r_release <= w_btn_update &  w_btn_level;
    end
  end

  assign btn_level_out   = w_btn_level;
  assign sw_level_out    = w_sw_level;
  assign btn_press_out   = r_press;
  assign btn_release_out = r_release;

`ifdef INPUT_DEBOUNCER_BTN_LATCH_EN
  logic [N_BTN-1:0] r_latch;

  // Sticky press flags for software polling; a new press wins over a same-cycle clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_latch <= '0;
    end else begin
      r_latch <= r_press | (r_latch & ~btn_latch_clr_in);
    end
  end

  assign btn_latch_out = r_latch;
`else
  logic [N_BTN-1:0] w_latch_clr_unused;

  assign w_latch_clr_unused = btn_latch_clr_in;
  assign btn_latch_out      = '0;
`endif

endmodule
